// File: rtl/ycbcr_conv_arbiter.sv
// Two pixel streams share one fixed-latency RGB->YCbCr converter. Round-robin grants are
// issued only against free output-FIFO credit, so results never need to stall.

module rgb_to_ycbcr #(
   parameter int LATENCY = 3
) (
   input  logic        clk_in,
   input  logic [29:0] rgb_in,
   output logic [29:0] ycc_out
);
   logic [29:0] rgb_q;
   logic [29:0] pipe [LATENCY-1];
   logic [21:0] r, g, b;
   logic [21:0] y_sum, cr_sum, cb_sum;
   logic [9:0]  y, cr, cb;

   assign r = {12'd0, rgb_q[29:20]};
   assign g = {12'd0, rgb_q[19:10]};
   assign b = {12'd0, rgb_q[9:0]};

   // Sums wrap mod 2^22; only bits [19:10] are kept, with no clamping.
   assign y_sum  = r * 22'h132 + g * 22'h259 + b * 22'h074;
   assign cr_sum = (r << 9) - g * 22'h1AD - b * 22'h053;
   assign cb_sum = (b << 9) - r * 22'h0AD - g * 22'h153;

   assign y  = 10'(y_sum >> 10);
   assign cr = 10'(cr_sum >> 10);
   assign cb = 10'(cb_sum >> 10);

   always_ff @(posedge clk_in) begin
      rgb_q   <= rgb_in;
      pipe[0] <= {y, cr, cb};
      for (int i = 1; i < LATENCY - 1; i++) begin
         pipe[i] <= pipe[i-1];
      end
   end

   assign ycc_out = pipe[LATENCY-2];
endmodule

module ycbcr_conv_arbiter #(
   parameter int FIFO_DEPTH   = 8,
   parameter int CONV_LATENCY = 3
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        a_valid_in,
   input  logic [29:0] a_rgb_in,
   output logic        a_ready_out,
   input  logic        b_valid_in,
   input  logic [29:0] b_rgb_in,
   output logic        b_ready_out,
   output logic        a_valid_out,
   output logic [29:0] a_ycc_out,
   input  logic        a_ready_in,
   output logic        b_valid_out,
   output logic [29:0] b_ycc_out,
   input  logic        b_ready_in
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = $clog2(CONV_LATENCY + 1);

   logic [1:0]              rst_sync;
   logic                    rst_n;
   logic                    active;
   logic                    last;
   logic [1:0]              in_valid, credit_ok, eligible, grant;
   logic [1:0]              push, out_valid, out_ready;
   logic [29:0]             in_rgb [2];
   logic [29:0]             out_ycc [2];
   logic [29:0]             conv_in, conv_out;
   logic [CONV_LATENCY-1:0] tag_valid, tag_id;

   assign in_valid  = {b_valid_in, a_valid_in};
   assign in_rgb[0] = a_rgb_in;
   assign in_rgb[1] = b_rgb_in;
   assign out_ready = {b_ready_in, a_ready_in};

   // Reset asserts asynchronously and releases on a clock edge.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) rst_sync <= 2'b00;
      else           rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   // Holds grants off while reset is asserted, so ready_out is 0 during reset.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) active <= 1'b0;
      else        active <= 1'b1;
   end

   assign eligible = in_valid & credit_ok & {2{active}};

   always_comb begin
      grant = eligible;
      if (eligible == 2'b11) grant = last ? 2'b01 : 2'b10;
   end

   // last = 1 means B was granted most recently, so A wins the next tie.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n)      last <= 1'b1;
      else if (|grant) last <= grant[1];
   end

   assign conv_in = grant[0] ? in_rgb[0] : (grant[1] ? in_rgb[1] : 30'd0);

   rgb_to_ycbcr #(.LATENCY(CONV_LATENCY)) u_conv (
      .clk_in (clk_in),
      .rgb_in (conv_in),
      .ycc_out(conv_out)
   );

   // Tags ride alongside the converter so each result knows its destination.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         tag_valid <= '0;
         tag_id    <= '0;
      end else begin
         tag_valid <= {tag_valid[CONV_LATENCY-2:0], |grant};
         tag_id    <= {tag_id[CONV_LATENCY-2:0], grant[1]};
      end
   end

   for (genvar p = 0; p < 2; p++) begin : g_port
      logic [29:0]   mem [FIFO_DEPTH];
      logic [AW-1:0] wr_ptr, rd_ptr;
      logic [CW-1:0] count;
      logic [IW-1:0] inflight;
      logic          pop;

      assign push[p]      = tag_valid[CONV_LATENCY-1] && (tag_id[CONV_LATENCY-1] == 1'(p));
      assign credit_ok[p] = (int'(count) + int'(inflight)) < FIFO_DEPTH;
      assign out_valid[p] = (count != '0);
      assign out_ycc[p]   = out_valid[p] ? mem[rd_ptr] : 30'd0;
      assign pop          = out_valid[p] && out_ready[p];

      always_ff @(posedge clk_in or negedge rst_n) begin
         if (!rst_n)                    inflight <= '0;
         else if (grant[p] && !push[p]) inflight <= inflight + IW'(1);
         else if (!grant[p] && push[p]) inflight <= inflight - IW'(1);
      end

      always_ff @(posedge clk_in) begin
         if (push[p]) mem[wr_ptr] <= conv_out;
      end

      always_ff @(posedge clk_in or negedge rst_n) begin
         if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push[p]) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push[p], pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end

   assign a_ready_out = grant[0];
   assign b_ready_out = grant[1];
   assign a_valid_out = out_valid[0];
   assign b_valid_out = out_valid[1];
   assign a_ycc_out   = out_ycc[0];
   assign b_ycc_out   = out_ycc[1];
endmodule

// File: tb/tb_ycbcr_conv_arbiter.sv
// Randomized bench for ycbcr_conv_arbiter: a credit/round-robin model and per-port
// scoreboards predict every ready, valid and result on each cycle.

module tb_ycbcr_conv_arbiter;
   localparam int DEPTH = 8;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        a_valid_in, b_valid_in, a_ready_in, b_ready_in;
   logic [29:0] a_rgb_in, b_rgb_in;
   logic        a_ready_out, b_ready_out, a_valid_out, b_valid_out;
   logic [29:0] a_ycc_out, b_ycc_out;

   typedef struct {
      logic [29:0] ycc;
      int          t;
   } ent_t;

   ent_t sb [2][$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   acc [2];
   int   pop [2];
   int   acc_cyc [2];
   bit   took [2];
   bit   last_b;
   bit   mon_en = 1'b0;

   ycbcr_conv_arbiter #(.FIFO_DEPTH(DEPTH), .CONV_LATENCY(3)) dut (
      .clk_in     (clk_in),
      .rst_n_in   (rst_n_in),
      .a_valid_in (a_valid_in),
      .a_rgb_in   (a_rgb_in),
      .a_ready_out(a_ready_out),
      .b_valid_in (b_valid_in),
      .b_rgb_in   (b_rgb_in),
      .b_ready_out(b_ready_out),
      .a_valid_out(a_valid_out),
      .a_ycc_out  (a_ycc_out),
      .a_ready_in (a_ready_in),
      .b_valid_out(b_valid_out),
      .b_ycc_out  (b_ycc_out),
      .b_ready_in (b_ready_in)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [29:0] refConvert(input logic [29:0] rgb);
      int r, g, b;
      logic [31:0] y, cr, cb;
      r  = int'(rgb[29:20]);
      g  = int'(rgb[19:10]);
      b  = int'(rgb[9:0]);
      y  = 32'(306 * r + 601 * g + 116 * b);
      cr = 32'(r * 512 - 429 * g - 83 * b);
      cb = 32'(b * 512 - 173 * r - 339 * g);
      return {y[19:10], cr[19:10], cb[19:10]};
   endfunction

   task automatic resetModel();
      for (int p = 0; p < 2; p++) begin
         sb[p].delete();
         acc[p]  = 0;
         pop[p]  = 0;
         took[p] = 1'b0;
         acc_cyc[p] = 0;
      end
      last_b = 1'b1;
   endtask

   // Per-cycle prediction: grants from credit = DEPTH - (accepted - popped),
   // results visible 4 cycles after acceptance, in order per port.
   task automatic monitorCycle();
      logic        vin [2];
      logic        rdy [2];
      logic        vo [2];
      logic        ri [2];
      logic [29:0] rgb [2];
      logic [29:0] yo [2];
      bit          elig [2];
      bit          ev;
      logic [29:0] ey;
      int          exp_g;
      string       nm;
      vin[0] = a_valid_in;  vin[1] = b_valid_in;
      rdy[0] = a_ready_out; rdy[1] = b_ready_out;
      vo[0]  = a_valid_out; vo[1]  = b_valid_out;
      ri[0]  = a_ready_in;  ri[1]  = b_ready_in;
      rgb[0] = a_rgb_in;    rgb[1] = b_rgb_in;
      yo[0]  = a_ycc_out;   yo[1]  = b_ycc_out;
      for (int p = 0; p < 2; p++) elig[p] = vin[p] && ((DEPTH - (acc[p] - pop[p])) > 0);
      if (elig[0] && elig[1]) exp_g = last_b ? 0 : 1;
      else if (elig[0])       exp_g = 0;
      else if (elig[1])       exp_g = 1;
      else                    exp_g = -1;
      checkOutput("a_ready_out", 32'(rdy[0]), 32'(exp_g == 0));
      checkOutput("b_ready_out", 32'(rdy[1]), 32'(exp_g == 1));
      for (int p = 0; p < 2; p++) begin
         nm = (p == 0) ? "a" : "b";
         ev = (sb[p].size() > 0) && (sb[p][0].t + 4 <= cyc);
         ey = ev ? sb[p][0].ycc : 30'd0;
         checkOutput({nm, "_valid_out"}, 32'(vo[p]), 32'(ev));
         checkOutput({nm, "_ycc_out"}, 32'(yo[p]), 32'(ey));
         if (vo[p] && ri[p]) begin
            pop[p]++;
            if (sb[p].size() > 0) void'(sb[p].pop_front());
         end
         took[p] = vin[p] && rdy[p];
         if (took[p]) begin
            sb[p].push_back('{ycc: refConvert(rgb[p]), t: cyc});
            acc[p]++;
            acc_cyc[p] = cyc;
            last_b = (p == 1);
         end
      end
   endtask

   always @(negedge clk_in) begin
      if (mon_en) monitorCycle();
   end

   // A pixel that was offered but not taken stays on the bus unchanged.
   task automatic applyStimulus(input int unsigned pa, input int unsigned pb,
                                input int unsigned ra, input int unsigned rb);
      @(posedge clk_in);
      #1;
      if (!a_valid_in || took[0]) begin
         a_valid_in = ($urandom_range(99) < pa);
         a_rgb_in   = 30'($urandom);
      end
      if (!b_valid_in || took[1]) begin
         b_valid_in = ($urandom_range(99) < pb);
         b_rgb_in   = 30'($urandom);
      end
      a_ready_in = ($urandom_range(99) < ra);
      b_ready_in = ($urandom_range(99) < rb);
   endtask

   task automatic idle(input int n);
      a_valid_in = 1'b0;
      b_valid_in = 1'b0;
      a_ready_in = 1'b1;
      b_ready_in = 1'b1;
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic waitTake(input int p, input string tag);
      int k = 0;
      while (k < 20) begin
         @(posedge clk_in);
         #1;
         k++;
         if (took[p]) break;
      end
      if (p == 0) a_valid_in = 1'b0;
      else        b_valid_in = 1'b0;
      checkOutput({tag, "_accept"}, 32'(took[p]), 32'd1);
   endtask

   task automatic waitValid(input int p, output int lat);
      int k = 0;
      while (!((p == 0) ? a_valid_out : b_valid_out) && k < 20) begin
         @(negedge clk_in);
         k++;
      end
      lat = cyc - acc_cyc[p];
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_a_ready"}, 32'(a_ready_out), 32'd0);
      checkOutput({tag, "_b_ready"}, 32'(b_ready_out), 32'd0);
      checkOutput({tag, "_a_valid"}, 32'(a_valid_out), 32'd0);
      checkOutput({tag, "_b_valid"}, 32'(b_valid_out), 32'd0);
      checkOutput({tag, "_a_ycc"}, 32'(a_ycc_out), 32'd0);
      checkOutput({tag, "_b_ycc"}, 32'(b_ycc_out), 32'd0);
   endtask

   task automatic releaseReset();
      a_valid_in = 1'b0;
      b_valid_in = 1'b0;
      @(negedge clk_in);
      rst_n_in = 1'b1;
      repeat (4) @(posedge clk_in);
      #1;
      resetModel();
      mon_en = 1'b1;
   endtask

   initial begin
      int lat;
      int a0, b0, k;
      rst_n_in   = 1'b0;
      a_valid_in = 1'b1;
      b_valid_in = 1'b1;
      a_rgb_in   = '1;
      b_rgb_in   = '1;
      a_ready_in = 1'b1;
      b_ready_in = 1'b1;
      resetModel();
      repeat (3) @(posedge clk_in);
      #1;
      checkResetOutputs("reset");
      releaseReset();
      idle(3);

      $display("[TB] white pixel on A");
      a_valid_in = 1'b1;
      a_rgb_in   = {10'd1023, 10'd1023, 10'd1023};
      waitTake(0, "white");
      waitValid(0, lat);
      checkOutput("white_latency", 32'(lat), 32'd4);
      checkOutput("white_ycc", 32'(a_ycc_out), 32'({10'd1022, 10'd0, 10'd0}));
      checkOutput("white_b_quiet", 32'(b_valid_out), 32'd0);
      idle(4);

      $display("[TB] red pixel on B");
      b_ready_in = 1'b0;
      b_valid_in = 1'b1;
      b_rgb_in   = {10'd1023, 10'd0, 10'd0};
      waitTake(1, "red");
      waitValid(1, lat);
      checkOutput("red_latency", 32'(lat), 32'd4);
      checkOutput("red_ycc", 32'(b_ycc_out), 32'({10'd305, 10'd511, 10'd851}));
      @(posedge clk_in);
      #1 b_ready_in = 1'b1;
      @(posedge clk_in);
      #1 b_ready_in = 1'b0;
      checkOutput("red_pop", 32'(b_valid_out), 32'd0);
      idle(6);

      $display("[TB] round-robin");
      a0 = acc[0];
      b0 = acc[1];
      repeat (40) applyStimulus(100, 100, 100, 100);
      idle(10);
      checkOutput("rr_a_count", 32'(acc[0] - a0), 32'd20);
      checkOutput("rr_b_count", 32'(acc[1] - b0), 32'd19);

      $display("[TB] backpressure isolation");
      a0 = acc[0];
      b0 = acc[1];
      repeat (30) applyStimulus(100, 100, 0, 100);
      checkOutput("bp_a_count", 32'(acc[0] - a0), 32'(DEPTH));
      checkOutput("bp_b_rate", 32'((acc[1] - b0) >= 20), 32'd1);
      a0 = acc[0];
      repeat (30) applyStimulus(100, 100, 100, 100);
      checkOutput("bp_a_resume", 32'((acc[0] - a0) > DEPTH), 32'd1);
      idle(12);

      $display("[TB] full rate");
      a0 = acc[0];
      repeat (101) applyStimulus(100, 0, 100, 100);
      checkOutput("full_rate", 32'(acc[0] - a0), 32'd100);
      idle(12);

      $display("[TB] random traffic");
      repeat (1500) applyStimulus(70, 60, 65, 45);
      idle(30);

      $display("[TB] reset mid-flight");
      a0 = acc[0];
      a_ready_in = 1'b0;
      a_valid_in = 1'b1;
      a_rgb_in   = 30'($urandom);
      k = 0;
      while ((acc[0] - a0) < 5 && k < 50) begin
         @(posedge clk_in);
         #1;
         k++;
         if (took[0]) a_rgb_in = 30'($urandom);
      end
      a_valid_in = 1'b0;
      checkOutput("mid_accepts", 32'(acc[0] - a0), 32'd5);
      checkOutput("mid_pre_valid", 32'(a_valid_out), 32'd1);
      #1;
      rst_n_in   = 1'b0;
      mon_en     = 1'b0;
      a_valid_in = 1'b1;
      b_valid_in = 1'b1;
      #1;
      checkResetOutputs("mid_reset");
      repeat (2) @(posedge clk_in);
      releaseReset();
      repeat (15) applyStimulus(0, 0, 100, 100);
      a_valid_in = 1'b1;
      a_rgb_in   = 30'($urandom);
      waitTake(0, "post_reset");
      waitValid(0, lat);
      checkOutput("post_reset_latency", 32'(lat), 32'd4);
      idle(10);
      mon_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/ycbcr_conv_arbiter.md
# ycbcr_conv_arbiter

Shares one `rgb_to_ycbcr` converter between two independent pixel streams (A and B) with valid/ready handshakes on every side. Because the converter has a fixed latency and cannot stall, this block tracks in-flight pixels with a tag pipeline. A per-port output FIFO absorbs downstream backpressure, and per-port credit counting guarantees that no FIFO ever overflows. The block sits between the capture/scaler front ends and the per-stream compression stages.

## Interface
- `FIFO_DEPTH`, default 8: entries per output FIFO. Must be a power of 2 and ≥4. Full single-port rate requires ≥5.
- `CONV_LATENCY`, default 3: latency of the converter in cycles. Fixed; it sizes the tag pipeline.
- `clk_in`  input  1  the only clock.
- `rst_n_in`  input  1  asynchronous, active-low reset.
- `a_valid_in`  input  1  stream A pixel is valid.
- `a_rgb_in`  input  30  stream A pixel, packed {r[9:0], g[9:0], b[9:0]}.
- `a_ready_out`  output  1  stream A pixel accepted this cycle (grant).
- `b_valid_in`, `b_rgb_in`, `b_ready_out`: same as the A ports, for stream B.
- `a_valid_out`  output  1  stream A FIFO is non-empty.
- `a_ycc_out`  output  30  stream A result, packed {y[9:0], cr[9:0], cb[9:0]}. Raw converter bits; cr/cb are two's complement.
- `a_ready_in`  input  1  downstream of A pops the FIFO head.
- `b_valid_out`, `b_ycc_out`, `b_ready_in`: same as the A output ports, for stream B.

## Operation
- **Credit per port.** `credit_x = FIFO_DEPTH − fifo_count_x − inflight_x`, computed from registered counters. Port x is eligible when `x_valid_in && credit_x > 0`.
- **Arbitration.** Round-robin with a one-bit `last` pointer.
  - Exactly one port eligible: that port is granted.
  - Both ports eligible: the port ≠ `last` is granted.
  - `last` updates only on a grant. After reset, `last = B`, so A wins the first tie.
- **Handshake.** `x_ready_out` is combinational and equals grant_x. At most one grant per cycle. A transfer occurs when `valid && ready`. Inputs are never buffered: a pixel that is not granted stays on the input bus.
- **Converter input mux.** Drives the granted pixel, or 0 when there is no grant.
- **Tag pipeline.** `CONV_LATENCY` stages of {valid, id}, loaded on grant and aligned with the converter output.
  - `inflight_x` increments on grant_x and decrements when a valid tag with id x leaves the last stage.
  - When that tag emerges, {y, cr, cb} is written into FIFO x.
- **Output FIFOs.** In-order, first-word-fall-through. `x_valid_out = !empty`. Popping on `x_valid_out && x_ready_in` frees the credit, which is visible the next cycle.
- **Overflow.** A write to a full FIFO cannot occur. A pop and a write in the same cycle to a full FIFO is legal and leaves the count unchanged.
- **Arithmetic.** Results are passed through bit-exact; there is no clamping.
  - y = (0x132·R + 0x259·G + 0x074·B)[19:10]
  - cr = ((R<<9) − 0x1AD·G − 0x053·B)[19:10], computed mod 2^22
  - cb = ((B<<9) − 0x0AD·R − 0x153·G)[19:10], computed mod 2^22

## Timing
- **Reset.** Asynchronous assert, synchronous release. All outputs are 0 during and after reset: `a/b_ready_out`, `a/b_valid_out`, `a/b_ycc_out`. FIFO pointers, counts, inflight counters and tag valids are cleared; `last = B`.
  - Converter datapath registers are not reset. Their contents are ignored because the tags are invalid.
  - Pixels in flight when reset asserts are discarded and never appear on an output.
- **Latency.** A pixel accepted at the edge ending cycle T appears on `x_valid_out` in cycle T+4: 3 converter stages plus 1 FIFO write.
- **Throughput.**
  - One active port, downstream always ready, `FIFO_DEPTH ≥ 5`: 1 pixel/cycle.
  - Both ports active: 1 pixel/cycle total, alternating between A and B.
- **Backpressure.** With downstream held off, a port accepts exactly `FIFO_DEPTH` pixels before its ready stays low. The other port is unaffected.
- **Counters.** `inflight_x` ≤ `CONV_LATENCY`. `fifo_count` is `$clog2(FIFO_DEPTH)+1` bits wide. Pointers wrap modulo `FIFO_DEPTH`.

## Test plan
- **White pixel.** Reset, then one A pixel {1023,1023,1023} → `a_valid_out` goes high exactly 4 cycles after accept with `a_ycc_out` = {1022,0,0}; B outputs never go valid.
- **Red pixel.** One B pixel {1023,0,0} → `b_ycc_out` = {305,511,851}, and `b_valid_out` drops after the pop.
- **Round-robin.** Both ports valid continuously, both downstreams ready → grants go A,B,A,B… starting with A; each output streams at 1/2 rate; sequence-numbered data stays in order per port.
- **Backpressure isolation.** `a_ready_in=0` while A and B both stream → A accepts exactly 8 pixels, then `a_ready_out` stays 0; B continues at 1/cycle; raising `a_ready_in` drains 8 A pixels in order and A resumes.
- **Full rate.** `FIFO_DEPTH=8`, only A active, `a_ready_in=1` → 100 pixels accepted in 100 consecutive cycles; outputs match the reference model in order.
- **Reset mid-flight.** Assert `rst_n_in` low asynchronously with 3 pixels in flight and 2 in FIFO A → all outputs 0 immediately; after release, no stale output appears, and the first new pixel goes through with 4-cycle latency.
